// File: rtl/screen_seq_mux_pkg.sv
// Shared screen codes and small helpers for the screen sequencer.
package screen_pkg;

    localparam int SCR_W = 2;

    typedef enum logic [1:0] {
        SCR_IDLE  = 2'd0,
        SCR_WAIT  = 2'd1,
        SCR_PLAY  = 2'd2,
        SCR_SCORE = 2'd3
    } screen_t;

    // Saturating 16-bit frame counter increment.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return val;
        end else begin
            return val + 16'd1;
        end
    endfunction

endpackage

// File: rtl/screen_seq_mux_pipe_delay.sv
// Reset-to-zero shift register; DEPTH of zero degenerates to a wire.
module pipe_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_sr
            logic [WIDTH-1:0] sr_r [DEPTH];

            // Shift the bus one stage per clock, clearing every stage on reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        sr_r[i] <= {WIDTH{1'b0}};
                    end
                end else begin
                    sr_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr_r[i] <= sr_r[i-1];
                    end
                end
            end

            assign dout = sr_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/screen_seq_mux.sv
// Frame-synchronous screen sequencer and pixel selector. Screen requests are
// held in a one-entry pending slot and only applied on a frame boundary so the
// displayed layer never changes mid-frame.
module screen_seq_mux
    import screen_pkg::*;
#(
    parameter int N_SCREENS      = 4,
    parameter int RGB_W          = 12,
    parameter int CNT_W          = 11,
    parameter int PIPE           = 2,
    parameter int TIMEOUT_FRAMES = 600
) (
    input  logic                       pclk,
    input  logic                       rst,
    input  logic [CNT_W-1:0]           hcount_in,
    input  logic [CNT_W-1:0]           vcount_in,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    input  logic                       hblnk_in,
    input  logic                       vblnk_in,
    input  logic [N_SCREENS*RGB_W-1:0] rgb_in,
    input  logic                       ev_play,
    input  logic                       ev_start,
    input  logic                       ev_over,
    input  logic                       ev_ack,
    output logic [CNT_W-1:0]           hcount_out,
    output logic [CNT_W-1:0]           vcount_out,
    output logic                       hsync_out,
    output logic                       vsync_out,
    output logic                       hblnk_out,
    output logic                       vblnk_out,
    output logic [RGB_W-1:0]           rgb_out,
    output logic [1:0]                 screen,
    output logic                       screen_chg,
    output logic [15:0]                wait_frames
);

    localparam int          BUS_W  = 2*CNT_W + 4 + RGB_W;
    localparam logic [15:0] TO_CNT = 16'(TIMEOUT_FRAMES);

    screen_t          screen_r;
    screen_t          pend_tgt_r;
    screen_t          req_tgt_s;
    logic             pend_vld_r;
    logic             req_vld_s;
    logic             prev_vblnk_r;
    logic             screen_chg_r;
    logic [15:0]      wait_frames_r;
    logic             fb_s;
    logic             timeout_s;
    logic [RGB_W-1:0] ch_s [N_SCREENS];
    logic [RGB_W-1:0] rgb_sel_s;
    logic [BUS_W-1:0] s1_r;
    logic [BUS_W-1:0] dly_s;

    assign fb_s      = vblnk_in & ~prev_vblnk_r;
    assign timeout_s = (TO_CNT != 16'd0) && (wait_frames_r == TO_CNT);

    // Work out which transition (if any) the current events ask for from the displayed screen.
    always_comb begin
        req_vld_s = 1'b0;
        req_tgt_s = screen_r;
        case (screen_r)
            SCR_IDLE: begin
                if (ev_play) begin
                    req_vld_s = 1'b1;
                    req_tgt_s = SCR_WAIT;
                end else begin
                    req_vld_s = 1'b0;
                end
            end
            SCR_WAIT: begin
                // Opponent start wins over a simultaneous timeout.
                if (ev_start) begin
                    req_vld_s = 1'b1;
                    req_tgt_s = SCR_PLAY;
                end else if (timeout_s) begin
                    req_vld_s = 1'b1;
                    req_tgt_s = SCR_IDLE;
                end else begin
                    req_vld_s = 1'b0;
                end
            end
            SCR_PLAY: begin
                if (ev_over) begin
                    req_vld_s = 1'b1;
                    req_tgt_s = SCR_SCORE;
                end else begin
                    req_vld_s = 1'b0;
                end
            end
            SCR_SCORE: begin
                if (ev_ack) begin
                    req_vld_s = 1'b1;
                    req_tgt_s = SCR_IDLE;
                end else begin
                    req_vld_s = 1'b0;
                end
            end
            default: begin
                req_vld_s = 1'b0;
                req_tgt_s = SCR_IDLE;
            end
        endcase
    end

    // Screen FSM: latch one pending request, apply it on the next frame boundary, count WAIT frames.
    always_ff @(posedge pclk) begin
        if (rst) begin
            screen_r      <= SCR_IDLE;
            pend_tgt_r    <= SCR_IDLE;
            pend_vld_r    <= 1'b0;
            prev_vblnk_r  <= 1'b0;
            screen_chg_r  <= 1'b0;
            wait_frames_r <= 16'd0;
        end else begin
            prev_vblnk_r <= vblnk_in;
            screen_chg_r <= 1'b0;
            if (fb_s && pend_vld_r) begin
                screen_r     <= pend_tgt_r;
                pend_vld_r   <= 1'b0;
                screen_chg_r <= 1'b1;
            end else if (!pend_vld_r && req_vld_s) begin
                pend_vld_r <= 1'b1;
                pend_tgt_r <= req_tgt_s;
            end
            if (fb_s && pend_vld_r && (pend_tgt_r == SCR_WAIT)) begin
                wait_frames_r <= 16'd0;
            end else if (fb_s && (screen_r == SCR_WAIT)) begin
                wait_frames_r <= sat_inc16(wait_frames_r);
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < N_SCREENS; k++) begin : g_ch
            assign ch_s[k] = rgb_in[k*RGB_W +: RGB_W];
        end
    endgenerate

    // Pick the layer for the displayed screen, blanking outside the active area.
    always_comb begin
        rgb_sel_s = {RGB_W{1'b0}};
        if (hblnk_in || vblnk_in) begin
            rgb_sel_s = {RGB_W{1'b0}};
        end else begin
            rgb_sel_s = ch_s[screen_r];
        end
    end

    // Stage 1: capture timing bus together with the selected pixel.
    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_r <= {BUS_W{1'b0}};
        end else begin
            s1_r <= {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_sel_s};
        end
    end

    pipe_delay #(
        .WIDTH (BUS_W),
        .DEPTH (PIPE - 1)
    ) u_dly (
        .clk  (pclk),
        .rst  (rst),
        .din  (s1_r),
        .dout (dly_s)
    );

    assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} = dly_s;
    assign screen      = screen_r;
    assign screen_chg  = screen_chg_r;
    assign wait_frames = wait_frames_r;

endmodule
